// File: rtl/fabric_switch_cfg_ctrl.sv
// Runtime route-table loader for one fabric_switch: assembles a framed config stream,
// quiesces and drains the switch, then commits atomically. Optional: FABRIC_SWITCH_CFG_MIX_CHECK_EN.
module fabric_switch_cfg_ctrl #(
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_OUTPUTS    = 4,
  parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0] CONNECTIVITY = '1,
  parameter int CFG_WORD_WIDTH = 8,
  parameter int DRAIN_TIMEOUT  = 256,
  localparam int NUM_CONNECTED = $countones(CONNECTIVITY),
  localparam int NUM_WORDS     = (NUM_CONNECTED + CFG_WORD_WIDTH - 1) / CFG_WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [CFG_WORD_WIDTH-1:0] cfg_data_i,
  input  logic                      cfg_last_i,
  input  logic                      sw_busy_i,
  output logic                      hold_o,
  output logic [NUM_CONNECTED-1:0]  route_table_o,
  output logic                      cfg_commit_o,
  output logic                      error_valid_o,
  output logic [15:0]               error_code_o
);

  localparam int SHW = NUM_WORDS * CFG_WORD_WIDTH;
  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(NUM_WORDS - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  localparam logic [15:0] FABRIC_OK                                  = 16'd0;
  localparam logic [15:0] CFG_SWITCH_ROUTE_MIX_INPUTS_TO_SAME_OUTPUT = 16'd1;
  localparam logic [15:0] CFG_SWITCH_CFG_LENGTH_MISMATCH             = 16'd5;
  localparam logic [15:0] RT_SWITCH_DRAIN_TIMEOUT                    = 16'd263;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_e;

  state_e                   state_q, state_d;
  logic [SHW-1:0]           shadow_q, shadow_d;
  logic [WCW-1:0]           word_cnt_q, word_cnt_d;
  logic [DCW-1:0]           drain_cnt_q, drain_cnt_d;
  logic [NUM_CONNECTED-1:0] route_q, route_d;
  logic                     err_valid_q, err_valid_d;
  logic [15:0]              err_code_q, err_code_d;
  logic                     accept;
  logic                     mix_err;

  assign accept = cfg_valid_i && cfg_ready_o;

`ifdef FABRIC_SWITCH_CFG_MIX_CHECK_EN
  // Walk the connectivity matrix output-major; shadow bits map to set mask bits in order.
  always_comb begin
    int k;
    int row;
    mix_err = 1'b0;
    k = 0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      row = 0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (CONNECTIVITY[o*NUM_INPUTS+i]) begin
          if (shadow_q[k]) row++;
          k++;
        end
      end
      if (row > 1) mix_err = 1'b1;
    end
  end
`else
  assign mix_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      word_cnt_q  <= '0;
      drain_cnt_q <= '0;
      route_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= FABRIC_OK;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      word_cnt_q  <= word_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      route_q     <= route_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    word_cnt_d  = word_cnt_q;
    drain_cnt_d = '0;
    route_d     = route_q;
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (word_cnt_q == WCW'(w)) shadow_d[w*CFG_WORD_WIDTH +: CFG_WORD_WIDTH] = cfg_data_i;
          end
          if (cfg_last_i != (word_cnt_q == LAST_WORD)) begin
            state_d     = S_ERROR;
            err_valid_d = 1'b1;
            err_code_d  = CFG_SWITCH_CFG_LENGTH_MISMATCH;
          end else if (cfg_last_i) begin
            state_d    = S_DRAIN;
            word_cnt_d = '0;
          end else begin
            state_d    = S_LOAD;
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        // An idle switch on the timeout cycle still counts as drained.
        if (!sw_busy_i) begin
          if (mix_err) begin
            state_d     = S_ERROR;
            err_valid_d = 1'b1;
            err_code_d  = CFG_SWITCH_ROUTE_MIX_INPUTS_TO_SAME_OUTPUT;
          end else begin
            state_d = S_DONE;
            route_d = shadow_q[NUM_CONNECTED-1:0];
          end
        end else if (DRAIN_TIMEOUT != 0 && drain_cnt_q == DRAIN_LAST) begin
          state_d     = S_ERROR;
          err_valid_d = 1'b1;
          err_code_d  = RT_SWITCH_DRAIN_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o   = (state_q == S_IDLE) || (state_q == S_LOAD);
    hold_o        = (state_q == S_DRAIN) || (state_q == S_DONE) || (state_q == S_ERROR);
    cfg_commit_o  = (state_q == S_DONE);
    route_table_o = route_q;
    error_valid_o = err_valid_q;
    error_code_o  = err_code_q;
  end

endmodule

// File: tb/tb_fabric_switch_cfg_ctrl.sv
// Self-checking bench for fabric_switch_cfg_ctrl (4x4 full connectivity, 8-bit words, timeout 12).
module tb_fabric_switch_cfg_ctrl;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        sw_busy = 1'b0;
  logic        hold;
  logic [15:0] rt;
  logic        cfg_commit;
  logic        error_valid;
  logic [15:0] error_code;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] rt_model = '0;

  always #5 clk = ~clk;

  fabric_switch_cfg_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data), .cfg_last_i(cfg_last),
    .sw_busy_i(sw_busy), .hold_o(hold), .route_table_o(rt), .cfg_commit_o(cfg_commit),
    .error_valid_o(error_valid), .error_code_o(error_code)
  );

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          busy;
    int          gap;
    logic [15:0] exp_rt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    sw_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_hold", hold, 0);
    chk("rst_rt", rt, 0);
    chk("rst_commit", cfg_commit, 0);
    chk("rst_err_valid", error_valid, 0);
    chk("rst_err_code", error_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rt_model = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the word.
  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data = d;
    cfg_last = l;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept_bound", n < 50, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
  endtask

  // Drain lasts busy+1 cycles, then the commit cycle: commit appears busy+2 cycles after the last word.
  task automatic wait_commit(input int busy, input logic [15:0] new_rt);
    int c = 0;
    logic seen = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (cfg_commit) seen = 1'b1;
      else begin
        chk("drain_hold", hold, 1);
        chk("drain_rt_kept", rt, rt_model);
      end
      if (c == busy + 1) sw_busy = 1'b0;
    end
    chk("commit_seen", seen, 1);
    chk("commit_latency", c, busy + 2);
    chk("commit_rt", rt, new_rt);
    chk("commit_hold", hold, 1);
    chk("commit_ready", cfg_ready, 0);
    rt_model = new_rt;
    @(negedge clk);
    chk("post_commit_pulse", cfg_commit, 0);
    chk("post_hold", hold, 0);
    chk("post_ready", cfg_ready, 1);
    chk("post_err", error_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input logic [7:0] w0, input logic [7:0] w1, input int busy,
                          input int gap, input logic [15:0] exp_rt);
    sw_busy = (busy > 0);
    send_word(w0, 1'b0);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    send_word(w1, 1'b1);
    wait_commit(busy, exp_rt);
  endtask

  // One-hot or empty row per output keeps random tables legal when the mix check is built in.
  function automatic logic [15:0] rand_table();
    logic [15:0] v;
`ifdef FABRIC_SWITCH_CFG_MIX_CHECK_EN
    int r;
    v = '0;
    for (int o = 0; o < 4; o++) begin
      r = $urandom_range(0, 4);
      if (r < 4) v[o*4+r] = 1'b1;
    end
`else
    v = 16'($urandom);
`endif
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    logic [15:0] t;
    tbl[0] = '{8'h21, 8'h84, 0,  0, 16'h8421};
    tbl[1] = '{8'h48, 8'h12, 3,  0, 16'h1248};
    tbl[2] = '{8'h10, 8'h80, TO - 1, 2, 16'h8010};
    tbl[3] = '{8'h00, 8'h00, 1,  1, 16'h0000};
    tbl[4] = '{8'h84, 8'h21, 7,  0, 16'h2184};
    tbl[5] = '{8'h21, 8'h84, 10, 0, 16'h8421};

    apply_reset();
    for (int i = 0; i < 6; i++)
      do_frame(tbl[i].w0, tbl[i].w1, tbl[i].busy, tbl[i].gap, tbl[i].exp_rt);

    for (int i = 0; i < 20; i++) begin
      t = rand_table();
      do_frame(t[7:0], t[15:8], int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 3)), t);
    end

    // Drain timeout: busy never falls.
    sw_busy = 1'b1;
    send_word(8'h55, 1'b0);
    send_word(8'haa, 1'b1);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk("to_hold", hold, 1);
      chk("to_rt_kept", rt, rt_model);
      chk("to_no_err_yet", error_valid, 0);
    end
    @(negedge clk);
    chk("to_err_valid", error_valid, 1);
    chk("to_err_code", error_code, 263);
    chk("to_ready", cfg_ready, 0);
    sw_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("to_no_commit", cfg_commit, 0);
      chk("to_hold_stays", hold, 1);
      chk("to_rt_stays", rt, rt_model);
      chk("to_code_stays", error_code, 263);
    end
    apply_reset();

    // Early last: error 5, later frame stalled.
    send_word(8'h21, 1'b1);
    @(negedge clk);
    chk("len_err_valid", error_valid, 1);
    chk("len_err_code", error_code, 5);
    chk("len_hold", hold, 1);
    cfg_valid = 1'b1;
    cfg_data = 8'h84;
    cfg_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("len_ready_low", cfg_ready, 0);
      chk("len_no_commit", cfg_commit, 0);
    end
    chk("len_rt_kept", rt, 0);
    apply_reset();

    // Missing last on final word.
    send_word(8'h21, 1'b0);
    send_word(8'h84, 1'b0);
    @(negedge clk);
    chk("len2_err_code", error_code, 5);
    chk("len2_err_valid", error_valid, 1);
    apply_reset();

    // Two inputs onto output 0.
`ifdef FABRIC_SWITCH_CFG_MIX_CHECK_EN
    send_word(8'h03, 1'b0);
    send_word(8'h00, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("mix_no_commit", cfg_commit, 0);
    end
    chk("mix_err_valid", error_valid, 1);
    chk("mix_err_code", error_code, 1);
    chk("mix_rt_kept", rt, 0);
    apply_reset();
`else
    do_frame(8'h03, 8'h00, 0, 0, 16'h0003);
`endif

    // Reset after word 0 discards the partial frame.
    do_frame(8'h21, 8'h84, 0, 0, 16'h8421);
    send_word(8'h48, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cfg_ready, 1);
    chk("mid_rst_hold", hold, 0);
    chk("mid_rst_rt", rt, 0);
    chk("mid_rst_err", error_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rt_model = '0;
    do_frame(8'h48, 8'h12, 0, 0, 16'h1248);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fabric_switch_cfg_ctrl.md
Name: fabric_switch_cfg_ctrl

Overview:
Runtime configuration controller for one fabric_switch instance. It accepts a framed stream of configuration words and assembles the compressed route table in a shadow register. It then quiesces the switch by asserting hold upstream, waits for in-flight traffic to drain, and atomically commits the new route table. It reports sticky errors in the common fabric error format.

Parameters:
NUM_INPUTS, 4, switch input count (1..256).
NUM_OUTPUTS, 4, switch output count (1..256).
CONNECTIVITY, all ones, NUM_OUTPUTS*NUM_INPUTS connectivity mask; must match the controlled switch.
CFG_WORD_WIDTH, 8, configuration word width (1..64).
DRAIN_TIMEOUT, 256, maximum cycles spent in DRAIN; 0 disables the timeout.
NUM_CONNECTED (localparam), $countones(CONNECTIVITY), route table width.
NUM_WORDS (localparam), ceil(NUM_CONNECTED/CFG_WORD_WIDTH), words per frame.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config word valid
cfg_ready  out  1  config word ready
cfg_data  in  CFG_WORD_WIDTH  config word
cfg_last  in  1  marks final word of frame
sw_busy  in  1  switch has a transfer in flight (OR of out_valid, supplied by wrapper)
hold  out  1  upstream must stop presenting in_valid to the switch
route_table  out  NUM_CONNECTED  drives switch cfg_route_table
cfg_commit  out  1  one-cycle pulse; route_table took a new value this cycle
error_valid  out  1  sticky error flag
error_code  out  16  error code (fabric_common.svh)

Behaviour:
- Reset: state IDLE, route_table=0, shadow=0, word_cnt=0, drain_cnt=0, cfg_commit=0, hold=0, error_valid=0, error_code=FABRIC_OK. Reset mid-frame discards the shadow and partial count.
- FSM states: IDLE, LOAD, DRAIN, DONE, ERROR.
- cfg_ready=1 only in IDLE and LOAD. A word is accepted on cfg_valid&&cfg_ready.
- hold=1 in DRAIN, DONE and ERROR; hold=0 otherwise. hold is a registered (Moore) output.
- Word k is written to shadow[k*CFG_WORD_WIDTH +: CFG_WORD_WIDTH]. Bits at or above NUM_CONNECTED in the final word are ignored.
- IDLE -> LOAD on acceptance of word 0, with word_cnt=1.
- If NUM_WORDS==1 and cfg_last=1 on word 0: IDLE -> DRAIN directly.
- LOAD: each accepted word increments word_cnt. On acceptance of word NUM_WORDS-1 with cfg_last=1 -> DRAIN.
- Length error: cfg_last=1 on an earlier word, or cfg_last=0 on word NUM_WORDS-1 -> ERROR with CFG_SWITCH_CFG_LENGTH_MISMATCH (16'd5).
- DRAIN: drain_cnt counts cycles spent in DRAIN.
  - If sw_busy=0 in a DRAIN cycle, the next edge loads route_table<=shadow and enters DONE.
  - If DRAIN_TIMEOUT!=0, sw_busy=1 and drain_cnt==DRAIN_TIMEOUT-1 -> ERROR with RT_SWITCH_DRAIN_TIMEOUT (16'd263). route_table is not updated.
- DONE: lasts one cycle with cfg_commit=1 and hold=1, then returns to IDLE. cfg_ready=1 again the following cycle.
- Latency: last word accepted at edge E0; DRAIN in cycle 1. If sw_busy=0 in cycle 1, route_table changes at E1, cfg_commit is high in cycle 2, and hold=0 from cycle 3. Minimum 3 cycles from last word to hold release.
- ERROR: terminal until reset. cfg_ready=0, hold=1, route_table keeps its last committed value.
  - error_valid=1 and error_code are set on the ERROR-entry edge.
  - Only the first error is latched.
- Simultaneous events: sw_busy deasserting on the timeout cycle counts as drained, so commit wins. A frame arriving while in DRAIN/DONE is stalled by cfg_ready=0.

Optional Feature:
Macro: FABRIC_SWITCH_CFG_MIX_CHECK_EN.
- Defined:
  - In DRAIN, the shadow is expanded against CONNECTIVITY in row-major order (output-major, input-minor).
  - If any output row has more than one set bit, the FSM enters ERROR instead of committing, with CFG_SWITCH_ROUTE_MIX_INPUTS_TO_SAME_OUTPUT (16'd1). route_table is unchanged.
  - The check is evaluated in the same cycle as the drain decision and takes priority over commit.
- Undefined: no check is made; illegal tables are committed and the switch itself flags them.

Test Plan:
1. Defaults (NUM_CONNECTED=16, W=8); frame 8'h21 then 8'h84 with last, sw_busy=0 -> route_table=16'h8421 at E1 after last; cfg_commit high for exactly 1 cycle; hold high for 2 cycles.
2. Same frame with sw_busy=1 for 10 cycles after the last word -> hold stays 1 and route_table keeps its old value until sw_busy falls; commit on the next edge.
3. DRAIN_TIMEOUT=4 with sw_busy held 1 -> after 4 DRAIN cycles error_valid=1 and error_code=263; cfg_ready=0, hold=1 and route_table unchanged until rst_n.
4. cfg_last=1 on word 0 (NUM_WORDS=2) -> ERROR with error_code=5; a following valid frame is not accepted.
5. With FABRIC_SWITCH_CFG_MIX_CHECK_EN, frame 16'h0003 (output 0 routed from inputs 0 and 1) -> error_code=1 and no cfg_commit. Without the macro, the same frame commits 16'h0003.
6. Assert rst_n=0 after word 0 is accepted -> all outputs return to reset values. A subsequent full frame 16'h1248 commits correctly.
